// File: rtl/gate_reduce_pkg.sv
// Shared types and helpers for the gate_reduce_unit frame reducer.
//   mode_e      : run-time operator select (values 6-7 are reserved)
//   base_op_e   : underlying non-inverting operator applied per beat
//   state_e     : frame state machine encoding
//   identity_fill / base_of / invert_of / is_reserved : per-mode decode
package gate_reduce_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2
  } base_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Modes 6-7 are not operators; they reduce as AND and flag an error.
  function automatic logic is_reserved(input logic [2:0] mode);
    return (mode > 3'(MODE_XNOR));
  endfunction

  // Identity value is either all ones (AND family) or all zeros; the
  // caller replicates this fill bit to the operand width.
  function automatic logic identity_fill(input logic [2:0] mode);
    return (mode == 3'(MODE_AND)) || (mode == 3'(MODE_NAND)) || is_reserved(mode);
  endfunction

  function automatic base_op_e base_of(input logic [2:0] mode);
    base_op_e op;
    case (mode)
      3'(MODE_OR), 3'(MODE_NOR):   op = OP_OR;
      3'(MODE_XOR), 3'(MODE_XNOR): op = OP_XOR;
      default:                     op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic invert_of(input logic [2:0] mode);
    return (mode == 3'(MODE_NAND)) || (mode == 3'(MODE_NOR)) || (mode == 3'(MODE_XNOR));
  endfunction

endpackage

// File: rtl/gate_reduce_unit_bitwise_op.sv
// Combinational accumulator step: result = acc OP data.
//   acc     : current accumulator (or identity value for a frame's first beat)
//   data    : incoming operand
//   base_op : AND / OR / XOR
//   result  : next accumulator value
module bitwise_op
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] data,
  input  base_op_e         base_op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = acc & data;
    case (base_op)
      OP_OR:   result = acc | data;
      OP_XOR:  result = acc ^ data;
      default: result = acc & data;
    endcase
  end

endmodule

// File: rtl/gate_reduce_unit.sv
// Streaming bitwise frame reducer. Beats of in_data are folded with the
// operator latched on the first beat of a frame; one registered result is
// presented per frame on a valid/ready output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake; in_data operand, in_last ends frame,
//                          in_mode selects operator (sampled on first beat only)
//   out_valid/out_ready  : output handshake
//   out_data             : reduced result (inverted for NAND/NOR/XNOR)
//   out_count / out_ovf  : saturating beat count and its sticky saturation flag
//   out_err              : frame used a reserved mode and was reduced as AND
module gate_reduce_unit
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] op_acc;
  base_op_e         op_sel;
  base_op_e         base;
  logic             inv;
  logic             err;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             accept;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACCUM: if (accept) state_next = in_last ? ST_DONE : ST_ACCUM;
      ST_DONE:           if (out_ready) state_next = ST_IDLE;
      default:           state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on the state register only, so in_ready has no
  // path from out_ready.
  always_comb begin
    in_ready  = (state != ST_DONE);
    out_valid = (state == ST_DONE);
  end

  // A single operator instance serves both the first beat (identity folded
  // with the new operand, operator from in_mode) and later beats (running
  // accumulator, operator latched for the frame).
  always_comb begin
    op_acc = acc;
    op_sel = base;
    if (state == ST_IDLE) begin
      op_acc = {WIDTH{identity_fill(in_mode)}};
      op_sel = base_of(in_mode);
    end
  end

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .acc     (op_acc),
    .data    (in_data),
    .base_op (op_sel),
    .result  (acc_next)
  );

  // Frame datapath. Nothing changes in DONE, which keeps the result stable
  // while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      base  <= OP_AND;
      inv   <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      acc <= acc_next;
      if (state == ST_IDLE) begin
        base  <= base_of(in_mode);
        inv   <= invert_of(in_mode);
        err   <= is_reserved(in_mode);
        ovf   <= 1'b0;
        count <= CNT_W'(1);
      end else if (count == CNT_MAX) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign out_data  = inv ? ~acc : acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign out_err   = err;

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Directed self-checking bench for gate_reduce_unit (WIDTH=8, CNT_W=2).
module tb_gate_reduce_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [2:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_count;
  logic       out_ovf;
  logic       out_err;

  int asserts_cnt = 0;
  int fail_cnt    = 0;

  gate_reduce_unit #(.WIDTH(8), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns #1 after the edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic [2:0] m);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_mode  = m;
    for (int i = 0; i < 20; i++) begin
      accepted = in_ready;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    if (!accepted) check_eq("accept_timeout", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    $display("beat  data=0x%02h last=%0b mode=%0d", d, l, m);
  endtask

  // Wait for a result, compare all result fields, then complete the handshake.
  task automatic get_result(input string tag, input logic [7:0] exp_data,
                            input logic [1:0] exp_count, input logic exp_ovf,
                            input logic exp_err);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"},  32'(out_data),  32'(exp_data));
    check_eq({tag, "_count"}, 32'(out_count), 32'(exp_count));
    check_eq({tag, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
    check_eq({tag, "_err"},   32'(out_err),   32'(exp_err));
    $display("frame %s data=0x%02h count=%0d ovf=%0b err=%0b", tag, out_data, out_count, out_ovf, out_err);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_drop"},  32'(out_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_mode   = 3'd0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_out_count", 32'(out_count), 32'd0);
    check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
    check_eq("rst_out_err",   32'(out_err),   32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-operand AND: 0xF0 & 0x3C = 0x30, valid the cycle after the last beat
    send_beat(8'hF0, 1'b0, 3'd0);
    check_eq("and2_mid_valid", 32'(out_valid), 32'd0);
    send_beat(8'h3C, 1'b1, 3'd0);
    check_eq("and2_latency", 32'(out_valid), 32'd1);
    get_result("and2", 8'h30, 2'd1 + 2'd1, 1'b0, 1'b0);

    // Single-operand NAND: ~0xA5 = 0x5A
    send_beat(8'hA5, 1'b1, 3'd3);
    get_result("nand1", 8'h5A, 2'd1, 1'b0, 1'b0);

    // XNOR latched on first beat, later mode 0 ignored, 3 idle cycles mid-frame:
    // 0x0F ^ 0xFF ^ 0x01 = 0xF1, inverted -> 0x0E
    send_beat(8'h0F, 1'b0, 3'd5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("xnor_gap_ready", 32'(in_ready),  32'd1);
    check_eq("xnor_gap_valid", 32'(out_valid), 32'd0);
    send_beat(8'hFF, 1'b0, 3'd0);
    send_beat(8'h01, 1'b1, 3'd0);
    get_result("xnor3", 8'h0E, 2'd3, 1'b0, 1'b0);

    // Reserved mode 7 reduces as AND and flags err: 0xF3 & 0x3F = 0x33
    send_beat(8'hF3, 1'b0, 3'd7);
    send_beat(8'h3F, 1'b1, 3'd7);
    get_result("rsvd", 8'h33, 2'd2, 1'b0, 1'b1);

    // Output backpressure with a pending beat on the input
    send_beat(8'hFF, 1'b0, 3'd0);
    send_beat(8'h0F, 1'b1, 3'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    in_mode  = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_in_ready",  32'(in_ready),  32'd0);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_out_data",  32'(out_data),  32'h0F);
      check_eq("bp_out_count", 32'(out_count), 32'd2);
      $display("stall cycle %0d in_ready=%0b out_data=0x%02h", i, in_ready, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_release_valid", 32'(out_valid), 32'd0);
    check_eq("bp_release_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_next_accepted", 32'(out_valid), 32'd1);
    get_result("bp_next", 8'h55, 2'd1, 1'b0, 1'b0);

    // Count saturation at 3 with CNT_W=2: five OR beats
    send_beat(8'h01, 1'b0, 3'd1);
    send_beat(8'h02, 1'b0, 3'd1);
    send_beat(8'h04, 1'b0, 3'd1);
    send_beat(8'h08, 1'b0, 3'd1);
    send_beat(8'h10, 1'b1, 3'd1);
    get_result("sat5", 8'h1F, 2'd3, 1'b1, 1'b0);
    send_beat(8'h80, 1'b1, 3'd1);
    get_result("after_sat", 8'h80, 2'd1, 1'b0, 1'b0);

    // Reset mid-frame after 2 of 4 beats
    send_beat(8'hFF, 1'b0, 3'd0);
    send_beat(8'hF0, 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_count", 32'(out_count), 32'd0);
    check_eq("rst_mid_ready", 32'(in_ready),  32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'hAA, 1'b0, 3'd0);
    send_beat(8'h0F, 1'b1, 3'd0);
    get_result("post_rst", 8'h0A, 2'd2, 1'b0, 1'b0);

    // Reset while holding a result: out_valid drops without a clock edge
    send_beat(8'hC3, 1'b1, 3'd0);
    check_eq("done_before_rst", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_done_valid", 32'(out_valid), 32'd0);
    check_eq("rst_done_data",  32'(out_data),  32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
    $finish;
  end

endmodule
